// File: rtl/onehot_decoder_seq_if.sv
// Request/strobe bundle for onehot_decoder_seq: decode requests and scan control in,
// registered one-hot strobe and status out.
interface onehot_decoder_seq_if #(
    parameter int SEL_W = 4
);
    localparam int OUT_W = 2 ** SEL_W;

    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic             scan_start;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic             busy;
    logic             scan_done;

    modport master (
        output in_valid, sel, en, scan_start,
        input  in_ready, out, out_valid, busy, scan_done
    );

    modport slave (
        input  in_valid, sel, en, scan_start,
        output in_ready, out, out_valid, busy, scan_done
    );
endinterface

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with single-request decode (latency 1, full throughput)
// and a sequential scan mode that walks every output once.
module onehot_decoder_seq #(
    parameter int SEL_W      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    onehot_decoder_seq_if.slave  bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    // Counter is one bit wider than sel so the terminal count never aliases onto index 0.
    localparam logic [SEL_W:0]   CNT_END  = (SEL_W+1)'(OUT_W);
    localparam logic [SEL_W:0]   CNT_LAST = (SEL_W+1)'(OUT_W - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [SEL_W:0]   r_cnt;
    logic [SEL_W:0]   w_cntNext;
    logic [OUT_W-1:0] r_out;
    logic [OUT_W-1:0] w_outActiveHigh;
    logic             r_outValid;
    logic             w_outValidNext;
    logic             r_scanDone;
    logic             w_scanDoneNext;
    logic             w_inReady;
    logic             w_accept;

    assign w_inReady = (r_state == IDLE) && !bus.scan_start;
    assign w_accept  = bus.in_valid && w_inReady;

    always_comb begin
        w_stateNext     = r_state;
        w_cntNext       = r_cnt;
        w_outActiveHigh = '0;
        w_outValidNext  = 1'b0;
        w_scanDoneNext  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.scan_start) begin
                    w_stateNext     = SCAN;
                    w_outActiveHigh = OUT_W'(1);
                    w_outValidNext  = 1'b1;
                    w_scanDoneNext  = (CNT_LAST == '0);
                    w_cntNext       = (SEL_W+1)'(1);
                end else if (w_accept) begin
                    w_outValidNext = 1'b1;
                    if (bus.en) begin
                        w_outActiveHigh = OUT_W'(1) << bus.sel;
                    end
                end
            end
            SCAN: begin
                // r_cnt holds the index to strobe at this edge; reaching OUT_W ends the walk.
                if (r_cnt == CNT_END) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else begin
                    w_outActiveHigh = OUT_W'(1) << r_cnt;
                    w_outValidNext  = 1'b1;
                    w_scanDoneNext  = (r_cnt == CNT_LAST);
                    w_cntNext       = r_cnt + (SEL_W+1)'(1);
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_out      <= INACTIVE;
            r_outValid <= 1'b0;
            r_scanDone <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_out      <= w_outActiveHigh ^ INACTIVE;
            r_outValid <= w_outValidNext;
            r_scanDone <= w_scanDoneNext;
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out       = r_out;
    assign bus.out_valid = r_outValid;
    assign bus.busy      = (r_state == SCAN);
    assign bus.scan_done = r_scanDone;
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench for onehot_decoder_seq: table vectors, directed scan/reset
// sequences, an active-low narrow instance and a randomized run against a queue model.
module tb_onehot_decoder_seq;
    logic clk;
    logic rst;
    int   vecCount;
    int   missCount;

    onehot_decoder_seq_if #(.SEL_W(4)) busA ();
    onehot_decoder_seq_if #(.SEL_W(2)) busB ();

    onehot_decoder_seq #(.SEL_W(4), .ACTIVE_LOW(0)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    onehot_decoder_seq #(.SEL_W(2), .ACTIVE_LOW(1)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    typedef struct {
        logic        v;
        logic [3:0]  sel;
        logic        en;
        logic [15:0] expOut;
        logic        expValid;
    } vec_t;

    vec_t        tbl [7];
    logic [3:0]  scanB [4];
    logic        rV;
    logic        rEn;
    logic        rScan;
    logic [3:0]  rSel;
    logic [31:0] expOut;
    logic        expValid;
    logic        expBusy;
    logic        expDone;
    logic        expReady;
    int          pend [$];
    int          idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] s, input logic e, input logic sc);
        busA.in_valid   = v;
        busA.sel        = s;
        busA.en         = e;
        busA.scan_start = sc;
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        tbl[0] = '{1'b1, 4'd9,  1'b1, 16'h0200, 1'b1};
        tbl[1] = '{1'b0, 4'd9,  1'b1, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 4'd0,  1'b1, 16'h0001, 1'b1};
        tbl[3] = '{1'b1, 4'd15, 1'b1, 16'h8000, 1'b1};
        tbl[4] = '{1'b1, 4'd3,  1'b1, 16'h0008, 1'b1};
        tbl[5] = '{1'b1, 4'd5,  1'b0, 16'h0000, 1'b1};
        tbl[6] = '{1'b0, 4'd5,  1'b0, 16'h0000, 1'b0};
        scanB[0] = 4'b1110;
        scanB[1] = 4'b1101;
        scanB[2] = 4'b1011;
        scanB[3] = 4'b0111;

        rst = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        busB.in_valid   = 1'b0;
        busB.sel        = 2'd0;
        busB.en         = 1'b0;
        busB.scan_start = 1'b0;
        #3;
        checkOutput("rst_out",   busA.out, 32'h0);
        checkOutput("rst_valid", busA.out_valid, 32'h0);
        checkOutput("rst_busy",  busA.busy, 32'h0);
        checkOutput("rst_done",  busA.scan_done, 32'h0);
        checkOutput("rst_ready", busA.in_ready, 32'h1);
        checkOutput("rstB_out",  busB.out, 32'hF);
        checkOutput("rstB_valid", busB.out_valid, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors; row 0 lands in the first cycle after reset release.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i].v, tbl[i].sel, tbl[i].en, 1'b0);
            #1 checkOutput($sformatf("tbl%0d_ready", i), busA.in_ready, 32'h1);
            @(negedge clk);
            checkOutput($sformatf("tbl%0d_out", i), busA.out, tbl[i].expOut);
            checkOutput($sformatf("tbl%0d_valid", i), busA.out_valid, tbl[i].expValid);
        end

        // Full scan with in_valid asserted (and ignored) during the walk.
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        #1 checkOutput("scan_ready0", busA.in_ready, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("scan%0d_out", i), busA.out, 32'd1 << i);
            checkOutput($sformatf("scan%0d_valid", i), busA.out_valid, 32'h1);
            checkOutput($sformatf("scan%0d_busy", i), busA.busy, 32'h1);
            checkOutput($sformatf("scan%0d_done", i), busA.scan_done, (i == 15) ? 32'h1 : 32'h0);
            applyStimulus(i < 15, 4'd3, 1'b1, 1'b1);
            #1 checkOutput($sformatf("scan%0d_ready", i), busA.in_ready, 32'h0);
            @(negedge clk);
        end
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        checkOutput("scanEnd_out",   busA.out, 32'h0);
        checkOutput("scanEnd_valid", busA.out_valid, 32'h0);
        checkOutput("scanEnd_busy",  busA.busy, 32'h0);
        checkOutput("scanEnd_done",  busA.scan_done, 32'h0);
        checkOutput("scanEnd_ready", busA.in_ready, 32'h1);
        @(negedge clk);

        // Scan wins over a simultaneous request; the held request decodes afterwards.
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b1);
        #1 checkOutput("race_ready", busA.in_ready, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("race%0d_out", i), busA.out, 32'd1 << i);
            checkOutput($sformatf("race%0d_busy", i), busA.busy, 32'h1);
            applyStimulus(1'b1, 4'd2, 1'b1, 1'b0);
            @(negedge clk);
        end
        checkOutput("race_readyAfter", busA.in_ready, 32'h1);
        checkOutput("race_idleValid",  busA.out_valid, 32'h0);
        @(negedge clk);
        checkOutput("race_heldOut",   busA.out, 32'h4);
        checkOutput("race_heldValid", busA.out_valid, 32'h1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("race_quiet", busA.out_valid, 32'h0);

        // Asynchronous reset in the middle of a scan.
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("abort%0d_out", i), busA.out, 32'd1 << i);
            if (i < 4) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_out",   busA.out, 32'h0);
        checkOutput("abort_busy",  busA.busy, 32'h0);
        checkOutput("abort_valid", busA.out_valid, 32'h0);
        checkOutput("abort_done",  busA.scan_done, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_ready", busA.in_ready, 32'h1);
        checkOutput("abort_busy2", busA.busy, 32'h0);
        applyStimulus(1'b1, 4'd7, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("abort_sel7",  busA.out, 32'h80);
        checkOutput("abort_done2", busA.scan_done, 32'h0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("abort_quiet", busA.out_valid, 32'h0);

        // Active-low narrow instance.
        busB.in_valid = 1'b1;
        busB.sel      = 2'd1;
        busB.en       = 1'b1;
        @(negedge clk);
        checkOutput("B_sel1",   busB.out, 32'hD);
        checkOutput("B_valid1", busB.out_valid, 32'h1);
        busB.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("B_idle", busB.out, 32'hF);
        busB.scan_start = 1'b1;
        @(negedge clk);
        busB.scan_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("Bscan%0d_out", i), busB.out, scanB[i]);
            checkOutput($sformatf("Bscan%0d_done", i), busB.scan_done, (i == 3) ? 32'h1 : 32'h0);
            @(negedge clk);
        end
        checkOutput("Bscan_end", busB.out, 32'hF);
        @(negedge clk);

        // Randomized run against a queue-of-pending-strobes model.
        expOut   = 32'h0;
        expValid = 1'b0;
        expBusy  = 1'b0;
        expDone  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            checkOutput("rnd_out",   busA.out, expOut);
            checkOutput("rnd_valid", busA.out_valid, expValid);
            checkOutput("rnd_busy",  busA.busy, expBusy);
            checkOutput("rnd_done",  busA.scan_done, expDone);
            checkOutput("rnd_onehot", ($countones(busA.out) <= 1), 32'h1);
            rScan = ($urandom_range(0, 19) == 0);
            rV    = 1'($urandom_range(0, 1));
            rSel  = 4'($urandom_range(0, 15));
            rEn   = ($urandom_range(0, 3) != 0);
            applyStimulus(rV, rSel, rEn, rScan);
            expReady = !expBusy && !rScan;
            #1 checkOutput("rnd_ready", busA.in_ready, expReady);
            if (expBusy) begin
                if (pend.size() > 0) begin
                    idx      = pend.pop_front();
                    expOut   = 32'd1 << idx;
                    expValid = 1'b1;
                    expDone  = (idx == 15);
                end else begin
                    expOut   = 32'h0;
                    expValid = 1'b0;
                    expDone  = 1'b0;
                    expBusy  = 1'b0;
                end
            end else if (rScan) begin
                for (int j = 1; j < 16; j++) pend.push_back(j);
                expOut   = 32'h1;
                expValid = 1'b1;
                expDone  = 1'b0;
                expBusy  = 1'b1;
            end else if (rV) begin
                expOut   = rEn ? (32'd1 << rSel) : 32'h0;
                expValid = 1'b1;
                expDone  = 1'b0;
            end else begin
                expOut   = 32'h0;
                expValid = 1'b0;
                expDone  = 1'b0;
            end
            @(negedge clk);
        end
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule

// File: doc/onehot_decoder_seq.md
ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

Interface
REQ-001 Parameter SEL_W, default 4, select width; the block SHALL support 1 <= SEL_W <= 6.
REQ-002 Parameter ACTIVE_LOW, default 0: when 1, every bit of out SHALL be inverted (active bit 0, inactive bits 1).
REQ-003 Derived constant OUT_W = 2**SEL_W SHALL set the output width and SHALL NOT be overridable.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  decode request present.
REQ-008 in_ready  output  1  decode request accepted this cycle when high with in_valid.
REQ-009 sel  input  SEL_W  index to decode.
REQ-010 en  input  1  sampled with an accepted request; 0 yields an all-inactive output strobe.
REQ-011 scan_start  input  1  request sequential walk of all OUT_W outputs.
REQ-012 out  output  OUT_W  registered one-hot strobe (polarity per ACTIVE_LOW).
REQ-013 out_valid  output  1  out carries a strobe this cycle.
REQ-014 busy  output  1  scan in progress.
REQ-015 scan_done  output  1  one-cycle pulse on final scan strobe.

Function
REQ-016 States SHALL be IDLE and SCAN; busy SHALL equal (state == SCAN).
REQ-017 in_ready SHALL be combinational: in_ready = (state == IDLE) && !scan_start.
REQ-018 Decode: in_valid && in_ready at rising edge k -> during cycle k+1, out = onehot(sel) if en = 1, else all inactive; out_valid = 1 in both cases.
REQ-019 onehot(i) SHALL have exactly bit i active and all other bits inactive.
REQ-020 Strobes SHALL last exactly one cycle; with no accepted request and no scan, out SHALL return to all inactive and out_valid to 0 on the next cycle.
REQ-021 Back-to-back accepted requests SHALL produce back-to-back strobes with no idle cycle (full throughput, latency 1).
REQ-022 scan_start high in IDLE at edge k -> state SCAN; during cycle k+1+i (i = 0..OUT_W-1), out = onehot(i) and out_valid = 1.
REQ-023 scan_done SHALL be 1 only during cycle k+OUT_W, coincident with onehot(OUT_W-1).
REQ-024 State SHALL return to IDLE at edge k+OUT_W; in_ready may assert in cycle k+OUT_W+1.
REQ-025 Simultaneous scan_start and in_valid in IDLE: scan SHALL win; the request is not accepted (in_ready = 0) and must be held by the source.
REQ-026 scan_start and in_valid SHALL be ignored while in SCAN; no restart, no extension.
REQ-027 The internal scan counter SHALL be SEL_W+1 bits wide or terminate by compare, so OUT_W-1 SHALL not wrap to 0 and re-strobe.
REQ-028 At most one out bit SHALL ever be active in any cycle.

Reset
REQ-029 rst high SHALL immediately (asynchronously) force: state IDLE, out all inactive (all 0, or all 1 if ACTIVE_LOW), out_valid 0, busy 0, scan_done 0, scan counter 0.
REQ-030 Reset asserted mid-scan SHALL abort the scan with no scan_done; after release the block SHALL be in IDLE with in_ready = 1 (absent scan_start).
REQ-031 A request presented in the first cycle after rst release SHALL be accepted and decoded normally.

Verification
REQ-032 SEL_W=4: sel=9, en=1, in_valid one cycle -> next cycle out = 0x0200, out_valid=1; following cycle out = 0x0000, out_valid=0.
REQ-033 SEL_W=4: sel = 0,15,3 back-to-back with en=1 -> out = 0x0001, 0x8000, 0x0008 on three consecutive cycles; sel=5 with en=0 -> out = 0x0000, out_valid=1.
REQ-034 SEL_W=4: scan_start pulse -> 16 consecutive cycles out = 0x0001 ... 0x8000, busy=1, in_ready=0; scan_done=1 only with 0x8000; in_valid during scan ignored.
REQ-035 SEL_W=4: scan_start and in_valid (sel=2) same cycle -> scan runs, in_ready=0; held request accepted after scan, out = 0x0004.
REQ-036 SEL_W=4: rst asserted asynchronously (mid-cycle) after 5th scan strobe -> out = 0x0000, busy=0 immediately; no scan_done; sel=7 after release -> out = 0x0080.
REQ-037 SEL_W=2, ACTIVE_LOW=1: reset -> out = 4'b1111; sel=1 -> out = 4'b1101; scan -> 1110, 1101, 1011, 0111.
